// File: rtl/cache_ctrl.sv
// Blocking controller for a 2-way cache_mem datapath: one CPU load/store at a time,
// tag compare, dirty-victim write-back, line fill, and saturating hit/miss counters.
module cache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 16,
  parameter int OFF_W  = $clog2(DATA_W / 8),
  parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] cm_addr,
  output logic              cm_rw,
  output logic [DATA_W-1:0] cm_wdata,
  output logic              cm_wvalid,
  output logic              cm_wdirty,
  output logic [TAG_W-1:0]  cm_wtag,
  output logic              cm_req_done,
  input  logic              cm_hit,
  input  logic [DATA_W-1:0] cm_rdata,
  input  logic              cm_rvalid,
  input  logic              cm_rdirty,
  input  logic [TAG_W-1:0]  cm_rtag,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t            state_reg, state_next;
  logic              req_rw_reg;
  logic [ADDR_W-1:0] req_addr_reg;
  logic [DATA_W-1:0] req_wdata_reg;
  logic [TAG_W-1:0]  victim_tag_reg;
  logic [DATA_W-1:0] victim_data_reg;
  logic              first_lookup_reg;
  logic [CNT_W-1:0]  hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              hit_inc, miss_inc;

  assign req_tag  = req_addr_reg[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr_reg[OFF_W +: IDX_W];
  assign cm_addr  = req_addr_reg;
  assign cm_wtag  = req_tag;
  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;

  // Only the lookup straight after accept counts as a hit; the re-lookup after a fill does not.
  assign hit_inc  = (state_reg == COMPARE) && cm_hit && first_lookup_reg;
  assign miss_inc = (state_reg == COMPARE) && !cm_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      req_rw_reg       <= 1'b0;
      req_addr_reg     <= '0;
      req_wdata_reg    <= '0;
      victim_tag_reg   <= '0;
      victim_data_reg  <= '0;
      first_lookup_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && cpu_valid) begin
        req_rw_reg       <= cpu_rw;
        req_addr_reg     <= cpu_addr;
        req_wdata_reg    <= cpu_wdata;
        first_lookup_reg <= 1'b1;
      end
      if (state_reg == COMPARE) begin
        first_lookup_reg <= 1'b0;
        if (!cm_hit) begin
          victim_tag_reg  <= cm_rtag;
          victim_data_reg <= cm_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (hit_inc && hit_cnt_reg != '1)
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      if (miss_inc && miss_cnt_reg != '1)
        miss_cnt_reg <= miss_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (cpu_valid) state_next = COMPARE;
      COMPARE: begin
        if (cm_hit)                      state_next = IDLE;
        else if (cm_rvalid && cm_rdirty) state_next = WRITEBACK;
        else                             state_next = ALLOCATE;
      end
      WRITEBACK: if (mem_ready) state_next = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_next = COMPARE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    cm_rw       = 1'b0;
    cm_wdata    = '0;
    cm_wvalid   = 1'b0;
    cm_wdirty   = 1'b0;
    cm_req_done = 1'b0;
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_reg)
      COMPARE: begin
        if (cm_hit) begin
          cpu_ready   = 1'b1;
          cm_req_done = 1'b1;
          if (req_rw_reg) begin
            cm_rw     = 1'b1;
            cm_wdata  = req_wdata_reg;
            cm_wvalid = 1'b1;
            cm_wdirty = 1'b1;
          end else begin
            cpu_rdata = cm_rdata;
          end
        end
      end
      WRITEBACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {victim_tag_reg, req_idx, {OFF_W{1'b0}}};
        mem_wdata = victim_data_reg;
      end
      ALLOCATE: begin
        mem_valid = 1'b1;
        mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
        // Fill lands in cache_mem on the same edge memory completes.
        if (mem_ready) begin
          cm_rw     = 1'b1;
          cm_wdata  = mem_rdata;
          cm_wvalid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
